// File: rtl/mem_seq_if.sv
// Request/response and memory-port bundle of the multi-byte bus sequencer.
// The "slave" modport is the sequencer side; "master" is the CPU control and memory side.
interface mem_seq_if #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 2,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
    logic                          i_req_valid;
    logic                          o_req_ready;
    logic                          i_req_wr;
    logic                          i_req_dec;
    logic [ADDR_W-1:0]             i_req_addr;
    logic [LEN_W-1:0]              i_req_len;
    logic [MAX_BYTES*DATA_W-1:0]   i_req_wdata;
    logic                          o_rsp_valid;
    logic [MAX_BYTES*DATA_W-1:0]   o_rsp_rdata;
    logic [ADDR_W-1:0]             o_rsp_addr;
    logic [ADDR_W-1:0]             o_mem_rd_addr;
    logic [DATA_W-1:0]             i_mem_rd_data;
    logic                          o_mem_wr_en;
    logic [ADDR_W-1:0]             o_mem_wr_addr;
    logic [DATA_W-1:0]             o_mem_wr_data;
    logic                          i_mem_wait;

    modport slave (
        input  i_req_valid, i_req_wr, i_req_dec, i_req_addr, i_req_len, i_req_wdata,
        input  i_mem_rd_data, i_mem_wait,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_addr,
        output o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
    );

    modport master (
        output i_req_valid, i_req_wr, i_req_dec, i_req_addr, i_req_len, i_req_wdata,
        output i_mem_rd_data, i_mem_wait,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_addr,
        input  o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
    );
endinterface

// File: rtl/mem_seq.sv
// M-cycle/T-state bus sequencer: runs one 1..MAX_BYTES sequential read or write
// transaction per request, stepping the address up or down once per byte.
module mem_seq #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 2,
    parameter int T_STATES  = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    mem_seq_if.slave bus
);
    localparam int               BUF_W   = MAX_BYTES * DATA_W;
    localparam int               T_W     = $clog2(T_STATES);
    localparam logic [T_W-1:0]   T_LAST  = T_W'(T_STATES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               wr_q, wr_d;
    logic               dec_q, dec_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [BUF_W-1:0]   wdata_q, wdata_d;
    logic [BUF_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [LEN_W-1:0]   eff_len_s;

    // Next-state and datapath: accept in IDLE, T-state/byte stepping in BUS, one-clock DONE.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        dec_d      = dec_q;
        len_d      = len_q;
        k_d        = k_q;
        t_d        = t_q;
        cur_d      = cur_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rsp_addr_d = rsp_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (bus.i_req_len > MAX_LEN) begin
            eff_len_s = MAX_LEN;
        end else begin
            eff_len_s = bus.i_req_len;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid) begin
                    wr_d    = bus.i_req_wr;
                    dec_d   = bus.i_req_dec;
                    len_d   = eff_len_s;
                    k_d     = {LEN_W{1'b0}};
                    t_d     = {T_W{1'b0}};
                    cur_d   = bus.i_req_addr;
                    wdata_d = bus.i_req_wdata;
                    rdata_d = {BUF_W{1'b0}};
                    if (bus.i_req_dec) begin
                        rsp_addr_d = bus.i_req_addr - ADDR_W'(eff_len_s);
                    end else begin
                        rsp_addr_d = bus.i_req_addr + ADDR_W'(eff_len_s);
                    end
                    if (eff_len_s == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUS;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                // Addresses launch at t=0 so they are settled from t=1 through the strobe.
                if (t_q == {T_W{1'b0}}) begin
                    if (wr_q) begin
                        wr_addr_d = cur_q;
                        wr_data_d = wdata_q[int'(k_q) * DATA_W +: DATA_W];
                    end else begin
                        rd_addr_d = cur_q;
                    end
                end else begin
                    rd_addr_d = rd_addr_q;
                end
                if (t_q == T_LAST) begin
                    if (!bus.i_mem_wait) begin
                        if (!wr_q) begin
                            rdata_d[int'(k_q) * DATA_W +: DATA_W] = bus.i_mem_rd_data;
                        end else begin
                            rdata_d = rdata_q;
                        end
                        t_d = {T_W{1'b0}};
                        k_d = k_q + LEN_W'(1);
                        if (dec_q) begin
                            cur_d = cur_q - ADDR_W'(1);
                        end else begin
                            cur_d = cur_q + ADDR_W'(1);
                        end
                        if (k_q == len_q - LEN_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BUS;
                        end
                    end else begin
                        t_d = t_q;
                    end
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            dec_q       <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            k_q         <= {LEN_W{1'b0}};
            t_q         <= {T_W{1'b0}};
            cur_q       <= {ADDR_W{1'b0}};
            wdata_q     <= {BUF_W{1'b0}};
            rdata_q     <= {BUF_W{1'b0}};
            rsp_addr_q  <= {ADDR_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            dec_q       <= dec_d;
            len_q       <= len_d;
            k_q         <= k_d;
            t_q         <= t_d;
            cur_q       <= cur_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // The strobe must drop in the same clock a wait appears, so it is gated live by i_mem_wait.
    assign bus.o_mem_wr_en   = (state_q == S_BUS) && wr_q && (t_q == T_LAST) && !bus.i_mem_wait;
    assign bus.o_req_ready   = ready_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rdata_q;
    assign bus.o_rsp_addr    = rsp_addr_q;
    assign bus.o_mem_rd_addr = rd_addr_q;
    assign bus.o_mem_wr_addr = wr_addr_q;
    assign bus.o_mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: directed requests push expected strobes, address probes
// and responses; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_seq;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mem_seq_if #(.ADDR_W(16), .DATA_W(8), .MAX_BYTES(2)) bus_if ();

    mem_seq #(.ADDR_W(16), .DATA_W(8), .MAX_BYTES(2), .T_STATES(4)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus_if.slave)
    );

    typedef struct { logic [15:0] rdata; logic [15:0] addr; int lat; } rsp_t;
    typedef struct { logic [15:0] addr; logic [7:0] data; int cyc; } str_t;
    typedef struct { int cyc; logic [15:0] addr; } prb_t;

    rsp_t rsp_q[$];
    str_t str_q[$];
    prb_t prb_q[$];

    logic [7:0] mem [0:65535];
    int n_cmp = 0;
    int n_bad = 0;
    int rel = 1000;
    int acc_cnt = 0;
    int wfrom = 1000;
    int wto = 1000;

    assign bus_if.i_mem_rd_data = mem[bus_if.o_mem_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp, rel);
        end
    endtask

    // Monitor: cycle index since accept, then compare whatever the DUT presents.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            rel = 1000;
        end else begin
            rel = rel + 1;
            if (prb_q.size() > 0 && prb_q[0].cyc == rel) begin
                prb_t p;
                p = prb_q.pop_front();
                chk("rd_addr", 32'(bus_if.o_mem_rd_addr), 32'(p.addr));
            end
            if (bus_if.o_mem_wr_en) begin
                if (str_q.size() == 0) begin
                    chk("unexpected_strobe_addr", 32'(bus_if.o_mem_wr_addr), 32'hDEAD_BEEF);
                end else begin
                    str_t s;
                    s = str_q.pop_front();
                    chk("strobe_addr", 32'(bus_if.o_mem_wr_addr), 32'(s.addr));
                    chk("strobe_data", 32'(bus_if.o_mem_wr_data), 32'(s.data));
                    chk("strobe_cycle", 32'(rel), 32'(s.cyc));
                end
            end
            if (bus_if.o_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_addr", 32'(bus_if.o_rsp_addr), 32'hDEAD_BEEF);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", 32'(bus_if.o_rsp_rdata), 32'(r.rdata));
                    chk("rsp_addr", 32'(bus_if.o_rsp_addr), 32'(r.addr));
                    chk("rsp_cycle", 32'(rel), 32'(r.lat));
                end
            end
            if (bus_if.i_req_valid && bus_if.o_req_ready) begin
                rel = 0;
                acc_cnt++;
            end
        end
    end

    // Wait driver: raise i_mem_wait for cycles wfrom..wto of the current transaction.
    always @(posedge i_clk) begin
        #1;
        bus_if.i_mem_wait = (rel + 1 >= wfrom) && (rel + 1 <= wto);
    end

    task automatic issue(input logic wr, input logic dec, input logic [15:0] addr,
                         input logic [1:0] len, input logic [15:0] wdata);
        bit ok;
        @(posedge i_clk); #1;
        bus_if.i_req_wr    = wr;
        bus_if.i_req_dec   = dec;
        bus_if.i_req_addr  = addr;
        bus_if.i_req_len   = len;
        bus_if.i_req_wdata = wdata;
        bus_if.i_req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge i_clk);
            if (bus_if.o_req_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge i_clk); #1;
        bus_if.i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clk);
            if (rsp_q.size() == 0 && str_q.size() == 0 && prb_q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("completion_timeout", 32'(rsp_q.size() + str_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(bus_if.o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus_if.o_rsp_valid), 32'd0);
        chk("rst_wr_en", 32'(bus_if.o_mem_wr_en), 32'd0);
        chk("rst_rdata", 32'(bus_if.o_rsp_rdata), 32'd0);
        chk("rst_rsp_addr", 32'(bus_if.o_rsp_addr), 32'd0);
        chk("rst_rd_addr", 32'(bus_if.o_mem_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(bus_if.o_mem_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus_if.o_mem_wr_data), 32'd0);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'hC000] = 8'h34; mem[16'hC001] = 8'h12;
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        mem[16'h4000] = 8'h9A; mem[16'h4001] = 8'hBC;
        mem[16'h6000] = 8'h5C;
        mem[16'h8001] = 8'h21; mem[16'h8000] = 8'h43;

        bus_if.i_req_valid = 1'b0; bus_if.i_req_wr = 1'b0; bus_if.i_req_dec = 1'b0;
        bus_if.i_req_addr = 16'h0000; bus_if.i_req_len = 2'd0; bus_if.i_req_wdata = 16'h0000;
        bus_if.i_mem_wait = 1'b0;
        #12;
        chk_reset_outputs();
        @(posedge i_clk); #1; i_rst_n = 1'b1;

        // 1: two-byte read, increment
        prb_q.push_back('{4, 16'hC000}); prb_q.push_back('{8, 16'hC001});
        rsp_q.push_back('{16'h1234, 16'hC002, 9});
        issue(1'b0, 1'b0, 16'hC000, 2'd2, 16'h0000); wait_done();

        // 2: one-byte write, decrement
        str_q.push_back('{16'hFF80, 8'hA5, 4});
        rsp_q.push_back('{16'h0000, 16'hFF7F, 5});
        issue(1'b1, 1'b1, 16'hFF80, 2'd1, 16'h00A5); wait_done();

        // 3: address wrap both directions
        prb_q.push_back('{4, 16'hFFFF}); prb_q.push_back('{8, 16'h0000});
        rsp_q.push_back('{16'hCDAB, 16'h0001, 9});
        issue(1'b0, 1'b0, 16'hFFFF, 2'd2, 16'h0000); wait_done();
        str_q.push_back('{16'h0000, 8'h88, 4}); str_q.push_back('{16'hFFFF, 8'h77, 8});
        rsp_q.push_back('{16'h0000, 16'hFFFE, 9});
        issue(1'b1, 1'b1, 16'h0000, 2'd2, 16'h7788); wait_done();

        // 4: wait at final T-state stretches by 3; wait at t=1 is ignored
        wfrom = 4; wto = 6;
        str_q.push_back('{16'h1000, 8'h11, 7}); str_q.push_back('{16'h1001, 8'h22, 11});
        rsp_q.push_back('{16'h0000, 16'h1002, 12});
        issue(1'b1, 1'b0, 16'h1000, 2'd2, 16'h2211); wait_done();
        wfrom = 2; wto = 2;
        str_q.push_back('{16'h2000, 8'h33, 4}); str_q.push_back('{16'h2001, 8'h44, 8});
        rsp_q.push_back('{16'h0000, 16'h2002, 9});
        issue(1'b1, 1'b0, 16'h2000, 2'd2, 16'h4433); wait_done();
        wfrom = 1000; wto = 1000;

        // 5: zero length, over-length clamp, valid held during BUS
        rsp_q.push_back('{16'h0000, 16'h3000, 1});
        issue(1'b0, 1'b0, 16'h3000, 2'd0, 16'h0000); wait_done();
        rsp_q.push_back('{16'h0000, 16'h3000, 1});
        issue(1'b1, 1'b0, 16'h3000, 2'd0, 16'hFFFF); wait_done();
        rsp_q.push_back('{16'hBC9A, 16'h4002, 9});
        issue(1'b0, 1'b0, 16'h4000, 2'd3, 16'h0000); wait_done();
        str_q.push_back('{16'h5000, 8'hDD, 4}); str_q.push_back('{16'h4FFF, 8'hEE, 8});
        rsp_q.push_back('{16'h0000, 16'h4FFE, 9});
        issue(1'b1, 1'b1, 16'h5000, 2'd3, 16'hEEDD); wait_done();

        a0 = acc_cnt;
        rsp_q.push_back('{16'h005C, 16'h6001, 5});
        @(posedge i_clk); #1;
        bus_if.i_req_wr = 1'b0; bus_if.i_req_dec = 1'b0; bus_if.i_req_addr = 16'h6000;
        bus_if.i_req_len = 2'd1; bus_if.i_req_valid = 1'b1;
        for (int i = 0; i < 50 && !bus_if.o_rsp_valid; i++) @(negedge i_clk);
        @(posedge i_clk); #1; bus_if.i_req_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("held_valid_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("held_valid_rsp_popped", 32'(rsp_q.size()), 32'd0);

        // 6: reset at t=2 of byte 1 of a two-byte write
        str_q.push_back('{16'h7000, 8'h55, 4});
        issue(1'b1, 1'b0, 16'h7000, 2'd2, 16'h6655);
        repeat (6) @(posedge i_clk);
        #1; i_rst_n = 1'b0;
        #1; chk_reset_outputs();
        repeat (2) @(posedge i_clk);
        #1; i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        chk("reset_strobes_left", 32'(str_q.size()), 32'd0);
        prb_q.push_back('{4, 16'h8001}); prb_q.push_back('{8, 16'h8000});
        rsp_q.push_back('{16'h4321, 16'h7FFF, 9});
        issue(1'b0, 1'b1, 16'h8001, 2'd2, 16'h0000); wait_done();

        repeat (4) @(negedge i_clk);
        chk("final_rsp_queue", 32'(rsp_q.size()), 32'd0);
        chk("final_strobe_queue", 32'(str_q.size()), 32'd0);
        chk("final_probe_queue", 32'(prb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
